// File: rtl/noc_tx_adapter_pkg.sv
// Shared NoC definitions for the injection adapter and its credit counter.
// Flit field widths match the ring router's local port.
package noc_tx_adapter_pkg;

  localparam int NOC_DEST_WIDTH        = 4;
  localparam int NOC_FLIT_WIDTH        = 256;
  localparam int NOC_FLIT_BUFFER_DEPTH = 2;

  typedef enum logic {
    TX_HEAD,
    TX_BODY
  } tx_state_t;

  // Counter must hold 0..depth inclusive.
  function automatic int credit_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_tx_adapter_if.sv
// Client-side valid/ready flit stream into the injection adapter.
// The master modport is the client; the slave modport is the adapter.
interface noc_tx_adapter_if #(
  parameter int DEST_WIDTH = 4,
  parameter int FLIT_WIDTH = 256
);

  logic [FLIT_WIDTH-1:0] tx_data;
  logic [DEST_WIDTH-1:0] tx_dest;
  logic                  tx_last;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_dest,
    output tx_last,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_dest,
    input  tx_last,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/noc_tx_adapter_credit_counter.sv
// Up/down credit counter saturating at DEPTH, with a sticky overflow flag.
// Shared by the injection and ejection adapters.
module credit_counter
  import noc_tx_adapter_pkg::*;
#(
  parameter int DEPTH = NOC_FLIT_BUFFER_DEPTH,
  parameter int CW    = credit_cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_err_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // A return with the counter full is dropped and flagged; dec_i never fires at zero.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({dec_i, inc_i})
      2'b10: cnt_d = cnt_q - CW'(1);
      2'b01: begin
        if (cnt_q == CW'(DEPTH)) err_d = 1'b1;
        else                     cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(DEPTH);
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign ovf_err_o = err_q;

endmodule

// File: rtl/noc_tx_adapter.sv
// Injection stage in front of a ring router's local input port: converts a
// valid/ready client stream into credit-gated send pulses with a per-packet dest lock.
module noc_tx_adapter
  import noc_tx_adapter_pkg::*;
#(
  parameter int DEST_WIDTH        = NOC_DEST_WIDTH,
  parameter int FLIT_WIDTH        = NOC_FLIT_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = NOC_FLIT_BUFFER_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_tx_adapter_if.slave       tx,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  pkt_active,
  output logic                  credit_err
);

  localparam int CW = credit_cnt_width(FLIT_BUFFER_DEPTH);

  logic [CW-1:0]         credits;
  logic                  accept;
  tx_state_t             state_q;
  logic [DEST_WIDTH-1:0] dest_lock_q;
  logic [FLIT_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0] dest_q;
  logic                  tail_q;
  logic                  send_q;

  // Ready looks only at the registered count; a credit returned now helps next cycle.
  assign tx.tx_ready = (credits != '0);
  assign accept      = tx.tx_valid & tx.tx_ready;

  credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec_i     (accept),
    .inc_i     (credit_in),
    .cnt_o     (credits),
    .ovf_err_o (credit_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TX_HEAD;
      dest_lock_q <= '0;
      data_q      <= '0;
      dest_q      <= '0;
      tail_q      <= 1'b0;
      send_q      <= 1'b0;
    end else begin
      send_q <= accept;
      if (accept) begin
        data_q <= tx.tx_data;
        tail_q <= tx.tx_last;
        case (state_q)
          TX_HEAD: begin
            dest_q      <= tx.tx_dest;
            dest_lock_q <= tx.tx_dest;
            state_q     <= tx.tx_last ? TX_HEAD : TX_BODY;
          end
          TX_BODY: begin
            // Body flits ignore tx_dest so the packet cannot be split across routes.
            dest_q <= dest_lock_q;
            if (tx.tx_last) state_q <= TX_HEAD;
          end
        endcase
      end
    end
  end

  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign is_tail_out = tail_q;
  assign send_out    = send_q;
  assign pkt_active  = (state_q == TX_BODY);

endmodule

// File: tb/tb_noc_tx_adapter.sv
// Scoreboard bench for noc_tx_adapter: the driver queues expected flits, a
// negedge monitor pops and compares each send_out pulse.
module tb_noc_tx_adapter;

  localparam int DW = 4;
  localparam int FW = 256;

  typedef struct packed {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic          pkt_active;
  logic          credit_err;

  int   checks = 0;
  int   errors = 0;
  int   sends  = 0;
  int   pushed = 0;
  exp_t sb_q[$];

  noc_tx_adapter_if #(.DEST_WIDTH(DW), .FLIT_WIDTH(FW)) tx_if ();

  noc_tx_adapter #(
    .DEST_WIDTH        (DW),
    .FLIT_WIDTH        (FW),
    .FLIT_BUFFER_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx          (tx_if.slave),
    .data_out    (data_out),
    .dest_out    (dest_out),
    .is_tail_out (is_tail_out),
    .send_out    (send_out),
    .credit_in   (credit_in),
    .pkt_active  (pkt_active),
    .credit_err  (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle(input logic cr);
    tx_if.tx_valid = 1'b0;
    credit_in      = cr;
  endtask

  // Drive a flit that the bench expects to be accepted at the next edge.
  task automatic flit(input logic [FW-1:0] d, input logic [DW-1:0] dst,
                      input logic last, input logic [DW-1:0] exp_dst, input logic cr);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = d;
    tx_if.tx_dest  = dst;
    tx_if.tx_last  = last;
    credit_in      = cr;
    sb_q.push_back('{data: d, dest: exp_dst, tail: last});
    pushed++;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && send_out) begin
      exp_t e;
      sends++;
      if (sb_q.size() == 0) begin
        check("unexpected_send", FW'(1), FW'(0));
      end else begin
        e = sb_q.pop_front();
        check("flit_data", data_out, e.data);
        check("flit_dest", FW'(dest_out), FW'(e.dest));
        check("flit_tail", FW'(is_tail_out), FW'(e.tail));
      end
    end
  end

  initial begin
    logic [FW-1:0] dC2;
    rst_n          = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    tx_if.tx_dest  = '0;
    tx_if.tx_last  = 1'b0;
    credit_in      = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Reset state
    check("rst_ready",   FW'(tx_if.tx_ready), FW'(1));
    check("rst_credits", FW'(dut.credits), FW'(2));
    check("rst_send",    FW'(send_out), FW'(0));
    check("rst_data",    data_out, FW'(0));
    check("rst_dest",    FW'(dest_out), FW'(0));
    check("rst_tail",    FW'(is_tail_out), FW'(0));
    check("rst_active",  FW'(pkt_active), FW'(0));
    check("rst_err",     FW'(credit_err), FW'(0));

    // Single-flit packet
    flit({8{32'hA0A0_0001}}, 4'd3, 1'b1, 4'd3, 1'b0);
    cyc();
    idle(1'b1);
    check("single_active",  FW'(pkt_active), FW'(0));
    check("single_credits", FW'(dut.credits), FW'(1));
    cyc();
    idle(1'b0);
    check("single_credit_back", FW'(dut.credits), FW'(2));

    // Three-flit packet, body tx_dest changes are ignored
    flit({8{32'hB000_0000}}, 4'd2, 1'b0, 4'd2, 1'b0);
    cyc();
    check("pkt_active_head", FW'(pkt_active), FW'(1));
    flit({8{32'hB000_0001}}, 4'd5, 1'b0, 4'd2, 1'b1);
    cyc();
    check("pkt_active_body", FW'(pkt_active), FW'(1));
    check("acc_cr_credits",  FW'(dut.credits), FW'(1));
    check("acc_cr_ready",    FW'(tx_if.tx_ready), FW'(1));
    flit({8{32'hB000_0002}}, 4'd7, 1'b1, 4'd2, 1'b1);
    cyc();
    check("pkt_active_tail", FW'(pkt_active), FW'(0));
    check("acc_cr_credits2", FW'(dut.credits), FW'(1));
    idle(1'b1);
    cyc();
    idle(1'b0);
    check("pkt_credits_back", FW'(dut.credits), FW'(2));

    // Back-to-back until credits run out
    flit({8{32'hC000_0000}}, 4'd9, 1'b1, 4'd9, 1'b0);
    cyc();
    flit({8{32'hC000_0001}}, 4'd10, 1'b1, 4'd10, 1'b0);
    cyc();
    check("b2b_ready_low",   FW'(tx_if.tx_ready), FW'(0));
    check("b2b_credits_0",   FW'(dut.credits), FW'(0));
    dC2 = {8{32'hC000_0002}};
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = dC2;
    tx_if.tx_dest  = 4'd11;
    tx_if.tx_last  = 1'b1;
    credit_in      = 1'b1;
    cyc();
    check("b2b_ready_after_credit", FW'(tx_if.tx_ready), FW'(1));
    flit(dC2, 4'd11, 1'b1, 4'd11, 1'b0);
    cyc();
    idle(1'b1);
    check("b2b_ready_low2", FW'(tx_if.tx_ready), FW'(0));
    cyc();
    idle(1'b1);
    cyc();
    idle(1'b0);
    check("b2b_credits_back", FW'(dut.credits), FW'(2));

    // Credit overflow
    idle(1'b1);
    cyc();
    idle(1'b0);
    check("ovf_err",     FW'(credit_err), FW'(1));
    check("ovf_credits", FW'(dut.credits), FW'(2));
    cyc();
    check("ovf_sticky",  FW'(credit_err), FW'(1));

    // Reset mid-packet
    flit({8{32'hD000_0000}}, 4'd4, 1'b0, 4'd4, 1'b0);
    cyc();
    idle(1'b0);
    check("mid_active", FW'(pkt_active), FW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_active", FW'(pkt_active), FW'(0));
    check("mid_rst_err",    FW'(credit_err), FW'(0));
    check("mid_rst_ready",  FW'(tx_if.tx_ready), FW'(1));
    cyc();
    rst_n = 1'b1;
    cyc();
    // A fresh packet after reset starts in HEAD and uses its own dest.
    flit({8{32'hE000_0000}}, 4'd6, 1'b1, 4'd6, 1'b0);
    cyc();
    idle(1'b0);
    check("post_rst_active", FW'(pkt_active), FW'(0));
    repeat (2) cyc();

    check("sb_drained", FW'(sb_q.size()), FW'(0));
    check("send_count", FW'(sends), FW'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_tx_adapter.md
# noc_tx_adapter

Endpoint-side injection stage that sits directly upstream of a ring router's local input port (port 0). Accepts packets from a client over a valid/ready stream and drives the router's credit-based flit interface (`send`/`credit`). It holds a credit counter that mirrors the router input buffer occupancy and locks the destination for the whole packet. It never sends a flit without a credit.

## Interface
Parameters:
- `DEST_WIDTH`, 4: destination endpoint id width.
- `FLIT_WIDTH`, 256: flit payload width.
- `FLIT_BUFFER_DEPTH`, 2: depth of the downstream router input buffer; also the initial credit count.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `tx_data`  in  FLIT_WIDTH: client flit payload.
- `tx_dest`  in  DEST_WIDTH: destination; sampled on head flit only.
- `tx_last`  in  1: marks the final flit of a packet.
- `tx_valid`  in  1: client flit valid.
- `tx_ready`  out  1: adapter accepts the flit this cycle.
- `data_out`  out  FLIT_WIDTH: flit to the router.
- `dest_out`  out  DEST_WIDTH: destination to the router.
- `is_tail_out`  out  1: tail marker to the router.
- `send_out`  out  1: flit valid to the router; one-cycle pulse per flit.
- `credit_in`  in  1: one buffer slot freed in the router; one-cycle pulse.
- `pkt_active`  out  1: a packet is in progress (state BODY).
- `credit_err`  out  1: sticky; a credit was returned while the counter was already full.

## Operation
- Credit counter `credits`, width `$clog2(FLIT_BUFFER_DEPTH+1)`:
  - Resets to FLIT_BUFFER_DEPTH.
  - Next value = `credits - accept + credit_in`.
  - Simultaneous accept and credit_in leaves it unchanged.
- `tx_ready = (credits != 0)`. It is combinational from the register and does not depend on `tx_valid` or `credit_in`. A credit arriving this cycle only helps next cycle.
- `accept = tx_valid & tx_ready`.
- State machine, two states:
  - HEAD (reset). On accept, `dest_out` takes `tx_dest` and `dest_lock` captures `tx_dest`. If `tx_last` is 1 (single-flit packet), stay in HEAD; otherwise go to BODY.
  - BODY. On accept, `dest_out` takes `dest_lock` and `tx_dest` is ignored. On an accepted flit with `tx_last` = 1, return to HEAD. Otherwise stay.
- Output register, updated every cycle:
  - `send_out <= accept`.
  - On accept, `data_out <= tx_data` and `is_tail_out <= tx_last`.
  - When not accepting, `data_out`, `dest_out` and `is_tail_out` hold their values. They are don't-care while `send_out` is 0.
- `pkt_active = (state == BODY)`.
- Credit overflow (`credit_in` with `credits == FLIT_BUFFER_DEPTH` and no accept that cycle):
  - The counter saturates at FLIT_BUFFER_DEPTH.
  - `credit_err` sets and stays set until reset.
- `tx_valid` dropping mid-packet is legal: the adapter stays in BODY indefinitely.

## Timing
- Latency: a flit accepted in cycle N shows `send_out` = 1 in cycle N+1.
- Throughput: one flit per cycle while credits are non-zero. Sustained rate needs a credit round trip of at most FLIT_BUFFER_DEPTH cycles.
- Reset values:
  - `send_out` = 0, `data_out` = 0, `dest_out` = 0, `is_tail_out` = 0.
  - `credits` = FLIT_BUFFER_DEPTH, `tx_ready` = 1, state = HEAD, `pkt_active` = 0, `credit_err` = 0.
- Reset mid-packet: the adapter returns to HEAD immediately and the partial packet is abandoned. The system must reset the router alongside.
- With `credits == 0`, `tx_ready` = 0 even if `credit_in` = 1 in the same cycle. Ready rises the following cycle.

## Structure
- Shared NoC package holds:
  - Flit field widths shared with the router: `DEST_WIDTH`, `FLIT_WIDTH` defaults.
  - The state enum `tx_state_t {TX_HEAD, TX_BODY}`.
  - A function `credit_cnt_width(depth)`.
- One natural sub-module: `credit_counter` (up/down saturating counter with the overflow flag), to be reused by the matching ejection adapter.

## Test plan
- Reset with DEPTH=2 -> `tx_ready` = 1, `credits` = 2, all outputs 0.
- Single-flit packet (dest=3, last=1) with credits available -> next cycle `send_out` = 1, `dest_out` = 3, `is_tail_out` = 1. State stays HEAD and `credits` goes to 1.
- Three-flit packet where `tx_dest` changes to 5, then 7 on body flits, head dest=2 -> all three flits carry `dest_out` = 2. `pkt_active` is 1 after the head and drops after the tail.
- Back-to-back flits, no credits returned, DEPTH=2 -> two `send_out` pulses, then `tx_ready` = 0. One `credit_in` pulse -> `tx_ready` = 1 on the next cycle and exactly one more flit goes out.
- Accept and `credit_in` in the same cycle at `credits` = 1 -> `credits` stays 1 and `tx_ready` stays 1.
- `credit_in` at `credits` = 2, no send -> `credit_err` = 1 (sticky) and `credits` stays 2. Asserting `rst_n` low mid-packet -> state HEAD and `credit_err` = 0.
